pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Next-generation fetch PC generator for the MIPS core.
- Owns the architectural fetch PC register and arbitrates N_SRC redirect sources by fixed priority. Typical sources: exception, branch, jr, jump.
- Advances sequentially by FETCH_WIDTH instructions per accepted request.
- Buffers redirects that arrive while the front end is frozen.
- Flags misaligned targets and parks until the next redirect.
- Sits between the decode/exception redirect producers and the I-cache request port.

Parameters:
- N_SRC, 4, number of redirect sources; index 0 is highest priority.
- FETCH_WIDTH, 1, instructions per fetch request; 1, 2 or 4.
- ADDR_W, 32, PC width.
- RESET_PC, 32'hBFC0_0000, PC after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- redirect_valid_i  in  N_SRC  per-source redirect request, one-cycle pulse.
- redirect_pc_i  in  N_SRC*ADDR_W  per-source target; source k occupies bits [k*ADDR_W +: ADDR_W].
- hold_i  in  1  front-end freeze (cache miss, global stall).
- pc_ready_i  in  1  fetch accepts the current request.
- pc_o  out  ADDR_W  current fetch PC.
- pc_valid_o  out  1  pc_o is a valid fetch request.
- addr_err_o  out  1  pc_o is not word aligned (AdEL on fetch).
- pending_o  out  1  a buffered redirect is waiting.
- redirect_src_o  out  $clog2(N_SRC) (min 1)  index of the last redirect applied.

Behaviour:
- Reset, asynchronous:
  - pc_o=RESET_PC, pending cleared, state=RUN.
  - addr_err_o=0, redirect_src_o=0.
  - pc_valid_o=0 while resetn=0.
- States:
  - RUN: normal fetch.
  - ERR: misaligned PC parked.
  - The pending flag is orthogonal to state.
- pc_valid_o = (state==RUN) & ~hold_i & ~pending. Combinational from registered state, pending and hold_i.
- Priority select: winner = lowest index k with redirect_valid_i[k]=1.
- Step = FETCH_WIDTH*4. Sequential next PC = (pc & ~(Step-1)) + Step, so a misaligned-within-group PC realigns to the next group. Wraps modulo 2^ADDR_W.
- Edge update order, highest first:
  1. hold_i=1 and any redirect valid:
     - no pending: latch winner into pending;
     - pending with index p: replace only if winner index <= p.
     - pc_o unchanged.
  2. hold_i=1, no redirect: hold all state.
  3. hold_i=0 and (redirect valid or pending): load the higher-priority of winner vs pending (new redirect wins ties), then:
     - pc_o <= target; clear pending;
     - redirect_src_o <= index;
     - state <= ERR if target[1:0]!=0, else RUN.
     - Applies regardless of pc_ready_i; an unaccepted in-flight request is cancelled.
  4. hold_i=0, no redirect, state=RUN, pc_valid_o & pc_ready_i: pc_o <= sequential next.
  5. Otherwise hold.
- Latencies:
  - Redirect with hold_i=0 at edge t: pc_o=target, pc_valid_o=1 after edge t.
  - Redirect during hold: pending_o=1 after the capture edge. At the first edge with hold_i=0, pc_o<=target. pc_valid_o is 0 during that release cycle because pending is still set, and 1 the cycle after.
- ERR:
  - pc_valid_o=0, addr_err_o=1, pc_o holds the bad address for the exception unit.
  - No sequential advance; only a redirect leaves ERR.
- addr_err_o = (state==ERR).
- Stable request: pc_o and pc_valid_o are unchanged while pc_valid_o=1 and pc_ready_i=0, unless a redirect arrives (rule 3).
- Reset mid-hold or with pending: everything returns to reset values immediately; the pending redirect is lost.
- Redirect arriving in the same cycle as a handshake: the redirect wins; the sequential increment is discarded.

Test Plan:
- Reset release, FETCH_WIDTH=1, pc_ready_i=1 constant -> pc_o sequence BFC00000, BFC00004, BFC00008; pc_valid_o=0 during reset, 1 from the first cycle after.
- Simultaneous redirect_valid_i=4'b1010 (src1=80001000, src3=80002000), hold_i=0 -> pc_o=80001000 next cycle, redirect_src_o=1.
- hold_i=1 for 5 cycles; src2=80003000 at cycle 1, src0=BFC00380 at cycle 3, src1 at cycle 4 -> pending_o=1, pc_o frozen. On release pc_o=BFC00380, redirect_src_o=0, pending_o clears; pc_valid_o=1 one cycle later.
- pc_ready_i=0 for 3 cycles at pc=80000010 -> pc_o stable; pc_ready_i=1 -> next pc=80000014.
- Redirect to 80000102 -> addr_err_o=1, pc_valid_o=0, pc_o=80000102 held 10 cycles; then src0=BFC00380 -> RUN, addr_err_o=0.
- FETCH_WIDTH=4, redirect to 80000014 -> pc_o 80000014, then 80000020, then 80000030; also pc=FFFFFFF0 wraps to 00000000.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator for the MIPS front end.
// It holds the architectural fetch PC and picks one of N_SRC redirect sources
// by fixed priority, where index 0 is the highest priority. With no redirect
// it advances by FETCH_WIDTH words per accepted request.
// A redirect that arrives while the front end is frozen is buffered in a
// pending slot. A misaligned target parks the unit in ERR until the next
// redirect.
module pc_redirect_unit #(
  parameter int              N_SRC       = 4,
  parameter int              FETCH_WIDTH = 1,
  parameter int              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'hBFC0_0000,
  localparam int             SRC_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_SRC-1:0]        redirect_valid_i,
  input  logic [N_SRC*ADDR_W-1:0] redirect_pc_i,
  input  logic                    hold_i,
  input  logic                    pc_ready_i,
  output logic [ADDR_W-1:0]       pc_o,
  output logic                    pc_valid_o,
  output logic                    addr_err_o,
  output logic                    pending_o,
  output logic [SRC_W-1:0]        redirect_src_o
);

  typedef enum logic {RUN, ERR} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(FETCH_WIDTH * 4);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              pending_reg, pending_next;
  logic [SRC_W-1:0]  pend_idx_reg, pend_idx_next;
  logic [ADDR_W-1:0] pend_pc_reg, pend_pc_next;
  logic [SRC_W-1:0]  src_reg, src_next;

  logic [ADDR_W-1:0] target_arr [N_SRC];
  logic              any_valid;
  logic [SRC_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_pc;
  logic              take_new;
  logic [SRC_W-1:0]  sel_idx;
  logic [ADDR_W-1:0] sel_pc;
  logic [ADDR_W-1:0] seq_pc;

  // Unpack the flat target bus into one entry per source.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
      assign target_arr[gi] = redirect_pc_i[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Fixed-priority pick. The loop scans from the lowest priority upwards, so
  // the lowest valid index is the one left standing.
  always_comb begin
    win_idx = '0;
    win_pc  = target_arr[0];
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (redirect_valid_i[k]) begin
        win_idx = SRC_W'(k);
        win_pc  = target_arr[k];
      end
    end
  end

  assign any_valid = |redirect_valid_i;
  // A new redirect beats the buffered one when its priority is equal or better.
  assign take_new  = any_valid && (!pending_reg || (win_idx <= pend_idx_reg));
  assign sel_idx   = take_new ? win_idx : pend_idx_reg;
  assign sel_pc    = take_new ? win_pc  : pend_pc_reg;

  // Realign to the start of the current fetch group, then step one group.
  assign seq_pc = (pc_reg & ~(STEP - ADDR_W'(1))) + STEP;

  // The request is valid only when running, unfrozen, with nothing buffered.
  // It is also gated by reset so that nothing is requested while reset is held.
  assign pc_valid_o     = resetn && (state_reg == RUN) && !hold_i && !pending_reg;
  assign pc_o           = pc_reg;
  assign addr_err_o     = (state_reg == ERR);
  assign pending_o      = pending_reg;
  assign redirect_src_o = src_reg;

  // Next-state selection: buffer during hold, else apply a redirect, else advance.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    pending_next  = pending_reg;
    pend_idx_next = pend_idx_reg;
    pend_pc_next  = pend_pc_reg;
    src_next      = src_reg;
    if (hold_i) begin
      if (take_new) begin
        pending_next  = 1'b1;
        pend_idx_next = win_idx;
        pend_pc_next  = win_pc;
      end
    end else if (any_valid || pending_reg) begin
      // An unaccepted in-flight request is simply dropped here.
      pc_next      = sel_pc;
      pending_next = 1'b0;
      src_next     = sel_idx;
      state_next   = (sel_pc[1:0] != 2'b00) ? ERR : RUN;
    end else if ((state_reg == RUN) && pc_valid_o && pc_ready_i) begin
      pc_next = seq_pc;
    end
  end

  // State registers; the buffered redirect is discarded on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      pending_reg  <= 1'b0;
      pend_idx_reg <= '0;
      pend_pc_reg  <= '0;
      src_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pending_reg  <= pending_next;
      pend_idx_reg <= pend_idx_next;
      pend_pc_reg  <= pend_pc_next;
      src_reg      <= src_next;
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit.
// One instance uses FETCH_WIDTH=1 and a second uses FETCH_WIDTH=4.
// Inputs change 1 ns after the rising edge. Registered outputs are checked
// 1 ns after the edge.
module tb_pc_redirect_unit;

  logic         clk = 1'b0;
  logic         resetn;

  logic [3:0]   rv1, rv4;
  logic [127:0] rp1, rp4;
  logic         hold1, hold4, rdy1, rdy4;

  logic [31:0]  pc1, pc4;
  logic         val1, val4, err1, err4, pend1, pend4;
  logic [1:0]   src1, src4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(.N_SRC(4), .FETCH_WIDTH(1), .ADDR_W(32), .RESET_PC(32'hBFC0_0000)) u_fw1 (
    .clk(clk), .resetn(resetn), .redirect_valid_i(rv1), .redirect_pc_i(rp1),
    .hold_i(hold1), .pc_ready_i(rdy1), .pc_o(pc1), .pc_valid_o(val1),
    .addr_err_o(err1), .pending_o(pend1), .redirect_src_o(src1)
  );

  pc_redirect_unit #(.N_SRC(4), .FETCH_WIDTH(4), .ADDR_W(32), .RESET_PC(32'hBFC0_0000)) u_fw4 (
    .clk(clk), .resetn(resetn), .redirect_valid_i(rv4), .redirect_pc_i(rp4),
    .hold_i(hold4), .pc_ready_i(rdy4), .pc_o(pc4), .pc_valid_o(val4),
    .addr_err_o(err4), .pending_o(pend4), .redirect_src_o(src4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    rv1 = '0; rp1 = '0; hold1 = 1'b0; rdy1 = 1'b1;
    rv4 = '0; rp4 = '0; hold4 = 1'b0; rdy4 = 1'b0;
    step();
    step();
    check_val("rst_valid", {31'd0, val1}, 32'd0);
    check_val("rst_pc", pc1, 32'hBFC0_0000);
    check_val("rst_err", {31'd0, err1}, 32'd0);
    check_val("rst_pend", {31'd0, pend1}, 32'd0);
    check_val("rst_src", {30'd0, src1}, 32'd0);

    // Release reset away from the edge; the request becomes valid right away.
    resetn = 1'b1;
    #1;
    check_val("rel_valid", {31'd0, val1}, 32'd1);
    check_val("seq0", pc1, 32'hBFC0_0000);
    step();
    check_val("seq1", pc1, 32'hBFC0_0004);
    step();
    check_val("seq2", pc1, 32'hBFC0_0008);

    // Two simultaneous redirects: source 1 outranks source 3.
    rv1 = 4'b1010;
    rp1[1*32 +: 32] = 32'h8000_1000;
    rp1[3*32 +: 32] = 32'h8000_2000;
    step();
    rv1 = '0;
    check_val("prio_pc", pc1, 32'h8000_1000);
    check_val("prio_src", {30'd0, src1}, 32'd1);
    check_val("prio_valid", {31'd0, val1}, 32'd1);

    // Hold for five edges while three redirects arrive.
    hold1 = 1'b1;
    #1;
    check_val("hold_valid", {31'd0, val1}, 32'd0);
    step();
    rv1 = 4'b0100; rp1[2*32 +: 32] = 32'h8000_3000;
    step();
    rv1 = '0;
    check_val("hold_pend", {31'd0, pend1}, 32'd1);
    step();
    rv1 = 4'b0001; rp1[0 +: 32] = 32'hBFC0_0380;
    step();
    rv1 = 4'b0010; rp1[1*32 +: 32] = 32'h8000_1000;
    step();
    rv1 = '0;
    check_val("hold_pc", pc1, 32'h8000_1000);
    check_val("hold_pend2", {31'd0, pend1}, 32'd1);
    hold1 = 1'b0;
    #1;
    check_val("rel_cycle_valid", {31'd0, val1}, 32'd0);
    step();
    check_val("rel_pc", pc1, 32'hBFC0_0380);
    check_val("rel_src", {30'd0, src1}, 32'd0);
    check_val("rel_pend", {31'd0, pend1}, 32'd0);
    check_val("rel_valid2", {31'd0, val1}, 32'd1);

    // This redirect lands on a handshake edge, so the increment is dropped.
    rv1 = 4'b1000; rp1[3*32 +: 32] = 32'h8000_0010;
    step();
    rv1 = '0;
    check_val("hs_redir_pc", pc1, 32'h8000_0010);
    check_val("hs_redir_src", {30'd0, src1}, 32'd3);
    rdy1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("stall_pc%0d", i), pc1, 32'h8000_0010);
      check_val($sformatf("stall_valid%0d", i), {31'd0, val1}, 32'd1);
    end
    rdy1 = 1'b1;
    step();
    check_val("stall_next", pc1, 32'h8000_0014);

    // A misaligned target parks the unit in ERR.
    rv1 = 4'b0100; rp1[2*32 +: 32] = 32'h8000_0102;
    step();
    rv1 = '0;
    check_val("err_pc", pc1, 32'h8000_0102);
    check_val("err_flag", {31'd0, err1}, 32'd1);
    check_val("err_valid", {31'd0, val1}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_val($sformatf("err_hold_pc%0d", i), pc1, 32'h8000_0102);
      check_val($sformatf("err_hold_flag%0d", i), {31'd0, err1}, 32'd1);
    end
    rv1 = 4'b0001; rp1[0 +: 32] = 32'hBFC0_0380;
    step();
    rv1 = '0;
    check_val("err_exit_flag", {31'd0, err1}, 32'd0);
    check_val("err_exit_pc", pc1, 32'hBFC0_0380);
    check_val("err_exit_valid", {31'd0, val1}, 32'd1);
    step();
    check_val("err_exit_seq", pc1, 32'hBFC0_0384);

    // Reset while a redirect is pending; the pending redirect is discarded.
    hold1 = 1'b1;
    rv1 = 4'b0100; rp1[2*32 +: 32] = 32'h8000_3000;
    step();
    rv1 = '0;
    check_val("pre_rst_pend", {31'd0, pend1}, 32'd1);
    resetn = 1'b0;
    #1;
    check_val("mid_rst_pend", {31'd0, pend1}, 32'd0);
    check_val("mid_rst_pc", pc1, 32'hBFC0_0000);
    check_val("mid_rst_valid", {31'd0, val1}, 32'd0);
    hold1 = 1'b0;
    resetn = 1'b1;
    step();
    check_val("post_rst_pc", pc1, 32'hBFC0_0004);
    check_val("post_rst_pend", {31'd0, pend1}, 32'd0);

    // Four-wide fetch: realign to the group, step 16 bytes, wrap past the top.
    check_val("fw4_idle_pc", pc4, 32'hBFC0_0000);
    rv4 = 4'b0001; rp4[0 +: 32] = 32'h8000_0014;
    step();
    rv4 = '0;
    check_val("fw4_redir", pc4, 32'h8000_0014);
    rdy4 = 1'b1;
    step();
    check_val("fw4_align", pc4, 32'h8000_0020);
    step();
    check_val("fw4_step", pc4, 32'h8000_0030);
    rv4 = 4'b0001; rp4[0 +: 32] = 32'hFFFF_FFF0;
    step();
    rv4 = '0;
    check_val("fw4_top", pc4, 32'hFFFF_FFF0);
    step();
    check_val("fw4_wrap", pc4, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
